ssc_mem_arbiter: RTL and testbench

//  Shares the sorter's single memory port (addrBus/outBus/inBus, readMem/writeMem/rdyMem) between
//  two requesters: port 0 = host loader/unloader, port 1 = selection-sort datapath.

---
 rtl/ssc_pkg.sv | 26 ++
 rtl/ssc_rr_pick.sv | 39 +++
 rtl/ssc_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ssc_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssc_pkg
// Purpose  : Shared types and constants for the selection-sort memory arbiter.
// Revision : 1.0
// ============================================================================
package ssc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic HOST = 1'b0;
    localparam logic SORT = 1'b1;

    localparam int unsigned SSC_AW = 8;
    localparam int unsigned SSC_DW = 16;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ssc_rr_pick
// Purpose  : Two-port round-robin picker with lock-owner masking.
// Revision : 1.0
// ============================================================================
module ssc_rr_pick
    import ssc_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       lock_valid_i,
    input  logic       lock_owner_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    logic [1:0] w_elig;

    always_comb begin
        w_elig = req_i;
        // A held lock hides the other port completely, even if the owner is not requesting.
        if (lock_valid_i && lock_i[lock_owner_i]) begin
            w_elig = req_i & port_onehot(lock_owner_i);
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        case (w_elig)
            2'b01:   gnt_o = port_onehot(HOST);
            2'b10:   gnt_o = port_onehot(SORT);
            2'b11:   gnt_o = port_onehot(~last_i);
            default: gnt_o = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ssc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ssc_mem_arbiter
// Purpose  : Shares one memory port between host and sorter with lock and timeout.
// Revision : 1.0
// ============================================================================
module ssc_mem_arbiter
    import ssc_pkg::*;
#(
    parameter int unsigned AW      = SSC_AW,
    parameter int unsigned DW      = SSC_DW,
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [1:0]    lock,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [1:0]    err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] addrBus,
    output logic [DW-1:0] outBus,
    input  logic [DW-1:0] inBus,
    output logic          readMem,
    output logic          writeMem,
    input  logic          rdyMem
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          last_q, last_d;
    logic          lock_valid_q, lock_valid_d;
    logic          lock_owner_q, lock_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    w_pick;
    logic          w_tmo;

    ssc_rr_pick u_pick (
        .req_i        (req),
        .lock_i       (lock),
        .lock_valid_i (lock_valid_q),
        .lock_owner_i (lock_owner_q),
        .last_i       (last_q),
        .gnt_o        (w_pick)
    );

    assign w_tmo = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        last_d       = last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                gnt_d = 2'b00;
                if (|w_pick) begin
                    gnt_d   = w_pick;
                    addr_d  = w_pick[1] ? addr1  : addr0;
                    wdata_d = w_pick[1] ? wdata1 : wdata0;
                    we_d    = we[w_pick[1]];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // A ready in the final allowed cycle still completes normally.
                if (rdyMem) begin
                    rdata_d = we_q ? '0 : inBus;
                    done_d  = gnt_q;
                    state_d = RESP;
                end else if (w_tmo) begin
                    rdata_d = '0;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d       = gnt_q[1];
                lock_owner_d = gnt_q[1];
                lock_valid_d = lock[gnt_q[1]];
                gnt_d        = 2'b00;
                cnt_d        = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            last_q       <= SORT;
            lock_valid_q <= 1'b0;
            lock_owner_q <= HOST;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            last_q       <= last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign addrBus  = addr_q;
    assign outBus   = wdata_q;
    assign readMem  = (state_q == ACCESS) && !we_q;
    assign writeMem = (state_q == ACCESS) &&  we_q;

endmodule
`default_nettype wire

// File: tb/tb_ssc_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ssc_mem_arbiter
// Purpose  : Vector, corner-case and randomized checks of ssc_mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_ssc_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = '0, we = '0, lock = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]    gnt, done, err;
    logic [DW-1:0] rdata, outBus;
    logic [AW-1:0] addrBus;
    logic [DW-1:0] inBus = '0;
    logic          readMem, writeMem;
    logic          rdyMem = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssc_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .addrBus(addrBus), .outBus(outBus), .inBus(inBus),
        .readMem(readMem), .writeMem(writeMem), .rdyMem(rdyMem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no completion within cycle budget", name);
    endtask

    // Structural invariants, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_excl", 32'(readMem & writeMem), 32'd0);
            chk("gnt_excl", 32'(gnt == 2'b11), 32'd0);
            chk("strobe_needs_gnt", 32'((readMem | writeMem) && (gnt == 2'b00)), 32'd0);
        end
    end

    task automatic do_reset();
        rst = 1'b1; req = '0; lock = '0; we = '0; rdyMem = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          rdy_at;     // ACCESS cycle carrying rdyMem, 0 = never
        logic [15:0] inb;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_access;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int  acc = 0;
        bit  seen = 0;
        @(negedge clk);
        req = v.req; we = {v.we, v.we}; lock = '0;
        addr0 = v.addr; addr1 = v.addr; wdata0 = v.wdata; wdata1 = v.wdata;
        inBus = v.inb; rdyMem = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            rdyMem = 1'b0;
            if (readMem | writeMem) begin
                acc++;
                chk("vec_addr", 32'(addrBus), 32'(v.addr));
                chk("vec_dir", 32'(writeMem), 32'(v.we));
                chk("vec_gnt", 32'(gnt), 32'(v.req));
                if (v.we) chk("vec_outbus", 32'(outBus), 32'(v.wdata));
                if (acc == v.rdy_at) rdyMem = 1'b1;
            end
            if (done != 2'b00) begin
                seen = 1;
                chk("vec_done", 32'(done), 32'(v.req));
                chk("vec_err", 32'(err), v.exp_err ? 32'(v.req) : 32'd0);
                chk("vec_rdata", 32'(rdata), 32'(v.exp_rdata));
                chk("vec_access_cycles", 32'(acc), 32'(v.exp_access));
                chk("vec_latency", 32'(c), 32'(v.exp_access + 1));
                req = '0;
            end
        end
        if (!seen) begin
            bound_fail("vec_done_wait");
            req = '0;
        end
    endtask

    vec_t vecs[6];

    logic [15:0] refmem[256];
    logic [15:0] devmem[256];

    initial begin
        logic [1:0] order[4];
        logic [1:0] grants[3];
        logic [1:0] prev_gnt, prev_req, exp_g;
        int n, ng, sdone, ndone, mem_delay;
        bit mem_busy, last, w;
        bit         active[2];
        int         waitc[2];
        logic [7:0]  paddr[2];
        logic [15:0] pwd[2];
        logic        pwe[2];

        vecs[0] = '{2'b01, 1'b1, 8'h10, 16'hBEEF, 3, 16'h0000, 16'h0000, 1'b0, 3};
        vecs[1] = '{2'b10, 1'b0, 8'h05, 16'h0000, 1, 16'h1234, 16'h1234, 1'b0, 1};
        vecs[2] = '{2'b01, 1'b0, 8'h7F, 16'h0000, 2, 16'hA5A5, 16'hA5A5, 1'b0, 2};
        vecs[3] = '{2'b10, 1'b1, 8'hFF, 16'h0F0F, 1, 16'hFFFF, 16'h0000, 1'b0, 1};
        vecs[4] = '{2'b01, 1'b0, 8'h00, 16'h0000, 0, 16'h5555, 16'h0000, 1'b1, TMO};
        vecs[5] = '{2'b10, 1'b1, 8'h33, 16'h1111, TMO, 16'h0000, 16'h0000, 1'b0, TMO};

        // Reset state
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", 32'({readMem, writeMem}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_addrbus", 32'(addrBus), 32'd0);
        chk("rst_outbus", 32'(outBus), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both ports held from reset alternate 0,1,0,1
        rst = 1'b1; req = 2'b11; we = 2'b00; lock = '0; addr0 = 8'h01; addr1 = 8'h02;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            rdyMem = readMem | writeMem;
            if (readMem) chk("alt_addr", 32'(addrBus), gnt[1] ? 32'h02 : 32'h01);
            if (done != 2'b00) begin order[n] = done; n++; end
        end
        if (n < 4) bound_fail("alt_wait");
        for (int i = 0; i < n; i++) chk("alt_order", 32'(order[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        req = '0; rdyMem = 1'b0;

        // Sorter lock keeps a pending host out across read+write
        do_reset();
        req = 2'b10; lock = 2'b10; we = 2'b00; addr1 = 8'h05; addr0 = 8'h09; wdata1 = 16'hCAFE;
        ng = 0; sdone = 0; prev_gnt = '0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            @(negedge clk);
            rdyMem = readMem | writeMem;
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin grants[ng] = gnt; ng++; end
            if (gnt == 2'b10) req[0] = 1'b1;
            if (ng == 2 && gnt == 2'b10 && (readMem | writeMem)) lock[1] = 1'b0;
            if (done == 2'b10) begin
                if (sdone == 0) we[1] = 1'b1; else req[1] = 1'b0;
                sdone++;
            end
            if (done == 2'b01) req[0] = 1'b0;
            prev_gnt = gnt;
        end
        if (ng < 3) bound_fail("lock_wait");
        for (int i = 0; i < ng; i++) chk("lock_grant", 32'(grants[i]), (i < 2) ? 32'h2 : 32'h1);
        req = '0; lock = '0; rdyMem = 1'b0;

        // Reset in the middle of an access
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 8'h44;
        @(negedge clk);
        chk("abort_pre_strobe", 32'(readMem), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", 32'({readMem, writeMem}), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        rst = 1'b0; req = '0; rdyMem = 1'b1;
        @(negedge clk);
        rdyMem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < 256; i++) begin refmem[i] = '0; devmem[i] = '0; end
        do_reset();
        last = 1'b1; mem_busy = 0; mem_delay = 0; ndone = 0;
        prev_gnt = '0; prev_req = '0;
        for (int p = 0; p < 2; p++) begin active[p] = 0; waitc[p] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                exp_g = (prev_req == 2'b11) ? (last ? 2'b01 : 2'b10) : prev_req;
                chk("rnd_gnt", 32'(gnt), 32'(exp_g));
                w = gnt[1];
                chk("rnd_addr", 32'(addrBus), 32'(paddr[w]));
                chk("rnd_dir", 32'(writeMem), 32'(pwe[w]));
                if (pwe[w]) chk("rnd_outbus", 32'(outBus), 32'(pwd[w]));
            end
            if (readMem | writeMem) begin
                inBus = devmem[addrBus];
                if (!mem_busy) begin mem_busy = 1; mem_delay = $urandom_range(0, 3); end
                if (mem_delay == 0) begin
                    rdyMem = 1'b1;
                    if (writeMem) devmem[addrBus] = outBus;
                end else begin
                    rdyMem = 1'b0;
                    mem_delay--;
                end
            end else begin
                mem_busy = 0;
                rdyMem = 1'($urandom_range(0, 1));
                inBus = 16'($urandom);
            end
            if (done != 2'b00) begin
                w = done[1];
                ndone++;
                chk("rnd_done_gnt", 32'(done), 32'(gnt));
                chk("rnd_err", 32'(err), 32'd0);
                if (pwe[w]) begin
                    chk("rnd_wr_rdata", 32'(rdata), 32'd0);
                    refmem[paddr[w]] = pwd[w];
                end else begin
                    chk("rnd_rd_rdata", 32'(rdata), 32'(refmem[paddr[w]]));
                end
                last = w; active[w] = 0; waitc[w] = 0; req[w] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (active[p]) begin
                    waitc[p]++;
                    if (waitc[p] > 60) begin
                        bound_fail("rnd_wait");
                        active[p] = 0; waitc[p] = 0; req[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    active[p] = 1;
                    paddr[p]  = 8'($urandom_range(0, 15));
                    pwd[p]    = 16'($urandom);
                    pwe[p]    = 1'($urandom_range(0, 1));
                    req[p]    = 1'b1;
                    we[p]     = pwe[p];
                end
            end
            addr0 = paddr[0]; addr1 = paddr[1]; wdata0 = pwd[0]; wdata1 = pwd[1];
            prev_gnt = gnt;
            prev_req = req;
        end
        chk("rnd_activity", 32'(ndone >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
